// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, special instruction
// words and the default boot address.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NopInstr       = 32'h0000_0013;
  localparam logic [31:0] EbreakInstr    = 32'h0010_0073;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // Redirect targets are forced to word alignment; low bits are dropped, not trapped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter flop with its next-PC selection: hold, sequential +4, or redirect.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] ResetPc = DefaultResetPc
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: boot/run/halt control, IF/ID pipeline register and a
// saturating count of fetched instructions.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DefaultResetPc,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] ByteLimit = 32'(IMEM_WORDS * 4);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc;
  logic         in_range;
  logic         latch;
  logic         clear_valid;
  logic         pc_inc;

  logic         if_id_valid_q;
  logic [31:0]  if_id_pc_q, if_id_instr_q;
  logic [31:0]  fetch_count_q;

  pc_register #(
    .ResetPc (RESET_PC)
  ) u_pc_register (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .inc_i         (pc_inc),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc)
  );

  assign in_range = (pc < ByteLimit);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect wins over stall in every state.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StBoot:  state_d = StRun;
        StRun: begin
          if (!stall_i) begin
            if (!in_range || (imem_instr_i == EbreakInstr)) begin
              state_d = StHalt;
            end
          end
        end
        StHalt:  state_d = StHalt;
        default: state_d = StBoot;
      endcase
    end
  end

  always_comb begin
    latch       = (state_q == StRun) && !redirect_i && !stall_i && in_range;
    pc_inc      = latch;
    clear_valid = redirect_i
                || (state_q == StBoot)
                || ((state_q == StRun) && !stall_i && !in_range)
                || ((state_q == StHalt) && !stall_i);
    halted_o    = (state_q == StHalt);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NopInstr;
    end else if (latch) begin
      if_id_valid_q <= 1'b1;
      if_id_pc_q    <= pc;
      if_id_instr_q <= imem_instr_i;
    end else if (clear_valid) begin
      if_id_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_count_q <= 32'h0000_0000;
    end else if (latch && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign imem_addr_o   = pc;
  assign if_id_valid_o = if_id_valid_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step queues the expected post-edge state, clocks
// once and checks the DUT against the dequeued expectation.
module tb_fetch_stage;

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halted;
    logic [31:0] count;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr;
  logic        if_id_valid, halted;
  logic [31:0] if_id_pc, if_id_instr, fetch_count;

  logic [31:0] mem [256];
  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'h0000_0000;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (256)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .if_id_valid_o (if_id_valid),
    .if_id_pc_o    (if_id_pc),
    .if_id_instr_o (if_id_instr),
    .halted_o      (halted),
    .fetch_count_o (fetch_count)
  );

  function automatic logic [31:0] word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                      input logic [31:0] ein, input logic eh, input logic [31:0] ecnt,
                      input logic [31:0] eaddr);
    exp_t e;
    reset       = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    e.valid = ev; e.pc = epc; e.instr = ein; e.halted = eh; e.count = ecnt; e.addr = eaddr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"},  {31'd0, if_id_valid}, {31'd0, e.valid});
      check({tag, "_pc"},     if_id_pc,             e.pc);
      check({tag, "_instr"},  if_id_instr,          e.instr);
      check({tag, "_halted"}, {31'd0, halted},      {31'd0, e.halted});
      check({tag, "_count"},  fetch_count,          e.count);
      check({tag, "_addr"},   imem_addr,            e.addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word(i);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset, boot, then free-running fetch of words 0..2 with a 2-cycle stall at PC=8.
    step("reset",  1, 0, 0, 0, 0, 32'h0,  Nop,      0, 0, 32'h0);
    step("boot",   0, 0, 0, 0, 0, 32'h0,  Nop,      0, 0, 32'h0);
    step("f0",     0, 0, 0, 0, 1, 32'h0,  word(0),  0, 1, 32'h4);
    step("f4",     0, 0, 0, 0, 1, 32'h4,  word(1),  0, 2, 32'h8);
    step("stall1", 0, 1, 0, 0, 1, 32'h4,  word(1),  0, 2, 32'h8);
    step("stall2", 0, 1, 0, 0, 1, 32'h4,  word(1),  0, 2, 32'h8);
    step("f8",     0, 0, 0, 0, 1, 32'h8,  word(2),  0, 3, 32'hC);

    // Redirect with misaligned target beats a concurrent stall.
    step("redir_st", 0, 1, 1, 32'h43, 0, 32'h8,  word(2),  0, 3, 32'h40);
    step("f40",      0, 0, 0, 0,      1, 32'h40, word(16), 0, 4, 32'h44);

    // EBREAK at 0x10 halts; halt holds PC until a redirect resumes fetch.
    mem[4] = Ebreak;
    step("redir10", 0, 0, 1, 32'h10, 0, 32'h40, word(16), 0, 4, 32'h40 - 32'h30);
    step("ebreak",  0, 0, 0, 0,      1, 32'h10, Ebreak,   1, 5, 32'h14);
    mem[4] = word(4);
    step("halt1",   0, 0, 0, 0,      0, 32'h10, Ebreak,   1, 5, 32'h14);
    step("halt_st", 0, 1, 0, 0,      0, 32'h10, Ebreak,   1, 5, 32'h14);
    step("redir0",  0, 0, 1, 32'h0,  0, 32'h10, Ebreak,   0, 5, 32'h0);
    step("resume",  0, 0, 0, 0,      1, 32'h0,  word(0),  0, 6, 32'h4);

    // Straight-line run through the whole memory, then out-of-range halt.
    step("reset2", 1, 0, 0, 0, 0, 32'h0, Nop, 0, 0, 32'h0);
    step("boot2",  0, 0, 0, 0, 0, 32'h0, Nop, 0, 0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      step("run", 0, 0, 0, 0, 1, 32'(4 * i), word(i), 0, 32'(i + 1), 32'(4 * i + 4));
    end
    step("oor1", 0, 0, 0, 0, 0, 32'h3FC, word(255), 1, 256, 32'h400);
    step("oor2", 0, 0, 0, 0, 0, 32'h3FC, word(255), 1, 256, 32'h400);

    // Reset in HALT overrides stall and redirect.
    step("reset3", 1, 1, 1, 32'h80, 0, 32'h0, Nop,     0, 0, 32'h0);
    step("boot3",  0, 0, 0, 0,      0, 32'h0, Nop,     0, 0, 32'h0);
    step("f0_3",   0, 0, 0, 0,      1, 32'h0, word(0), 0, 1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
